// File: rtl/br_svc_rx.sv
// BrLite service receiver: filters broadcast flits addressed to this PE and
// queues the storable ones in a FIFO that the NI drains with pop pulses.
module br_svc_rx #(
   parameter int unsigned DEPTH    = 8,
   parameter logic [15:0] SEQ_ADDR = 16'h0000
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     br_req_i,
   output logic                     br_ack_o,
   input  logic [105:0]             br_data_i,
   output logic                     br_svc_rx_o,
   input  logic                     br_svc_ack_i,
   output logic [87:0]              br_svc_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [1:0]               state_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [1:0] SVC_ALL    = 2'd0;
   localparam logic [1:0] SVC_TARGET = 2'd1;

   // Handshake: the local port raises br_req_i with the flit and holds both
   // until br_ack_o pulses for one cycle; a new flit is only taken after
   // br_req_i has dropped, so a held request is never accepted twice.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [87:0]      mem_q [DEPTH];

   logic [1:0]       svc;
   logic [15:0]      seq_target;
   logic [87:0]      entry;
   logic             storable;
   logic             room;
   logic             pop;
   logic             accept;
   logic             push;
   logic             unused_bits;

   assign svc        = br_data_i[105:104];
   assign seq_target = br_data_i[79:64];
   assign entry      = {br_data_i[103:96], br_data_i[95:80], br_data_i[63:48],
                        br_data_i[47:16], seq_target};
   assign unused_bits = ^br_data_i[15:0];

   assign storable = (svc == SVC_ALL) ||
                     ((svc == SVC_TARGET) && (seq_target == SEQ_ADDR));
   assign pop      = br_svc_ack_i && (count_q != '0);
   // A pop in the same cycle frees the slot, so a full queue can still accept.
   assign room     = (count_q < DEPTH_C) || pop;
   assign accept   = (state_q == ST_IDLE) && br_req_i && (!storable || room);
   assign push     = accept && storable;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)    state_d = ST_ACK;
         ST_ACK:                 state_d = ST_WAIT;
         ST_WAIT: if (!br_req_i) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      br_ack_o = 1'b0;
      if (state_q == ST_ACK) br_ack_o = 1'b1;
   end

   assign state_o = state_q;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is left uninitialised; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= entry;
   end

   assign br_svc_data_o = mem_q[rptr_q];
   assign br_svc_rx_o   = (count_q != '0);
   assign count_o       = count_q;

endmodule

// File: tb/tb_br_svc_rx.sv
// Directed bench for br_svc_rx: table of single flits plus hand-written
// sequences for backpressure, held requests, wrap-around and reset.
module tb_br_svc_rx;

   localparam int unsigned DEPTH = 8;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         br_req_i;
   logic         br_ack_o;
   logic [105:0] br_data_i;
   logic         br_svc_rx_o;
   logic         br_svc_ack_i;
   logic [87:0]  br_svc_data_o;
   logic [3:0]   count_o;
   logic [1:0]   state_o;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [87:0] exp_q[$];

   br_svc_rx #(.DEPTH(DEPTH), .SEQ_ADDR(16'h0000)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .br_req_i      (br_req_i),
      .br_ack_o      (br_ack_o),
      .br_data_i     (br_data_i),
      .br_svc_rx_o   (br_svc_rx_o),
      .br_svc_ack_i  (br_svc_ack_i),
      .br_svc_data_o (br_svc_data_o),
      .count_o       (count_o),
      .state_o       (state_o)
   );

   // Clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  svc;
      logic [7:0]  ksvc;
      logic [15:0] tgt;
      logic [31:0] payload;
      bit          store;
   } vec_t;

   function automatic logic [105:0] mk_flit(input logic [1:0] svc, input logic [7:0] ksvc,
                                            input logic [15:0] tgt, input logic [31:0] pl);
      logic [15:0] src;
      logic [15:0] prod;
      src  = 16'hA000 ^ pl[15:0];
      prod = 16'hB000 ^ pl[31:16];
      return {svc, ksvc, src, tgt, prod, pl, 16'h0000};
   endfunction

   function automatic logic [87:0] mk_entry(input logic [7:0] ksvc, input logic [15:0] tgt,
                                            input logic [31:0] pl);
      logic [15:0] src;
      logic [15:0] prod;
      src  = 16'hA000 ^ pl[15:0];
      prod = 16'hB000 ^ pl[31:16];
      return {ksvc, src, prod, pl, tgt};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Driver: full handshake, optionally holding req for extra cycles after ack.
   task automatic send_flit(input logic [105:0] d, input int hold);
      bit acked;
      acked = 1'b0;
      br_data_i = d;
      br_req_i  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (br_ack_o) begin
            acked = 1'b1;
            break;
         end
      end
      chk("ack_seen", 128'(acked), 128'd1);
      chk("ack_state", 128'(state_o), 128'(ST_ACK));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_ack_low", 128'(br_ack_o), 128'd0);
         chk("hold_state_wait", 128'(state_o), 128'(ST_WAIT));
      end
      br_req_i = 1'b0;
      if (hold == 0) begin
         tick();
         chk("ack_pulse_1cyc", 128'(br_ack_o), 128'd0);
         chk("wait_state", 128'(state_o), 128'(ST_WAIT));
      end
      tick();
      chk("back_idle", 128'(state_o), 128'(ST_IDLE));
   endtask

   task automatic pop_one();
      chk("head_data", 128'(br_svc_data_o), 128'(exp_q[0]));
      br_svc_ack_i = 1'b1;
      tick();
      br_svc_ack_i = 1'b0;
      void'(exp_q.pop_front());
      chk("count_after_pop", 128'(count_o), 128'(exp_q.size()));
   endtask

   task automatic drain();
      while (exp_q.size() != 0) pop_one();
      chk("rx_empty", 128'(br_svc_rx_o), 128'd0);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{2'd0, 8'h12, 16'h0000, 32'hCAFEBABE, 1'b1};
      vecs[1] = '{2'd1, 8'h21, 16'h0001, 32'h0BADF00D, 1'b0};
      vecs[2] = '{2'd2, 8'h22, 16'h0000, 32'h22222222, 1'b0};
      vecs[3] = '{2'd3, 8'h23, 16'h0000, 32'h33333333, 1'b0};
      vecs[4] = '{2'd1, 8'h34, 16'h0000, 32'h11112222, 1'b1};
      vecs[5] = '{2'd0, 8'h56, 16'h7777, 32'h33334444, 1'b1};

      rst_ni = 1'b0; br_req_i = 1'b0; br_svc_ack_i = 1'b0; br_data_i = '0;
      tick(); tick();
      chk("rst_ack", 128'(br_ack_o), 128'd0);
      chk("rst_count", 128'(count_o), 128'd0);
      chk("rst_rx", 128'(br_svc_rx_o), 128'd0);
      chk("rst_state", 128'(state_o), 128'(ST_IDLE));
      rst_ni = 1'b1;
      tick();

      // Table of single flits: filtering and first-entry head visibility
      for (int i = 0; i < 6; i++) begin
         send_flit(mk_flit(vecs[i].svc, vecs[i].ksvc, vecs[i].tgt, vecs[i].payload), 0);
         if (vecs[i].store) exp_q.push_back(mk_entry(vecs[i].ksvc, vecs[i].tgt, vecs[i].payload));
         chk($sformatf("vec%0d_count", i), 128'(count_o), 128'(exp_q.size()));
         chk($sformatf("vec%0d_head_ksvc", i), 128'(br_svc_data_o[87:80]), 128'h12);
         chk($sformatf("vec%0d_head_payload", i), 128'(br_svc_data_o[47:16]), 128'hCAFEBABE);
      end
      chk("rx_nonempty", 128'(br_svc_rx_o), 128'd1);
      drain();

      // Fill to DEPTH, 9th flit must be backpressured until a pop
      for (int i = 1; i <= 8; i++) begin
         send_flit(mk_flit(2'd0, 8'h40, 16'h0000, 32'(i)), 0);
         exp_q.push_back(mk_entry(8'h40, 16'h0000, 32'(i)));
      end
      chk("full_count", 128'(count_o), 128'd8);
      br_data_i = mk_flit(2'd0, 8'h40, 16'h0000, 32'd9);
      br_req_i  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_no_ack", 128'(br_ack_o), 128'd0);
         chk("bp_count", 128'(count_o), 128'd8);
      end
      chk("bp_head", 128'(br_svc_data_o), 128'(exp_q[0]));
      br_svc_ack_i = 1'b1;
      tick();
      br_svc_ack_i = 1'b0;
      chk("bp_release_ack", 128'(br_ack_o), 128'd1);
      chk("bp_release_count", 128'(count_o), 128'd8);
      void'(exp_q.pop_front());
      exp_q.push_back(mk_entry(8'h40, 16'h0000, 32'd9));
      br_req_i = 1'b0;
      tick(); tick();
      chk("bp_idle", 128'(state_o), 128'(ST_IDLE));

      // Simultaneous push+pop at full occupancy across pointer wrap
      for (int i = 0; i < 20; i++) begin
         chk("pp_head", 128'(br_svc_data_o), 128'(exp_q[0]));
         br_data_i    = mk_flit(2'd0, 8'h77, 16'h0000, 32'(100 + i));
         br_req_i     = 1'b1;
         br_svc_ack_i = 1'b1;
         tick();
         br_svc_ack_i = 1'b0;
         chk("pp_ack", 128'(br_ack_o), 128'd1);
         chk("pp_count", 128'(count_o), 128'd8);
         void'(exp_q.pop_front());
         exp_q.push_back(mk_entry(8'h77, 16'h0000, 32'(100 + i)));
         br_req_i = 1'b0;
         tick(); tick();
         chk("pp_idle", 128'(state_o), 128'(ST_IDLE));
      end
      drain();

      // Request held high after ack: exactly one push
      send_flit(mk_flit(2'd0, 8'h55, 16'h0000, 32'h5555AAAA), 5);
      exp_q.push_back(mk_entry(8'h55, 16'h0000, 32'h5555AAAA));
      chk("hold_count", 128'(count_o), 128'd1);
      drain();

      // Reset during ACK abandons the flit; pop on empty is ignored
      br_data_i = mk_flit(2'd0, 8'h66, 16'h0000, 32'h66666666);
      br_req_i  = 1'b1;
      tick();
      chk("pre_rst_ack", 128'(br_ack_o), 128'd1);
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_ack", 128'(br_ack_o), 128'd0);
      chk("rst_mid_count", 128'(count_o), 128'd0);
      chk("rst_mid_rx", 128'(br_svc_rx_o), 128'd0);
      br_req_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      br_svc_ack_i = 1'b1;
      tick();
      br_svc_ack_i = 1'b0;
      chk("empty_pop_count", 128'(count_o), 128'd0);
      chk("empty_pop_rx", 128'(br_svc_rx_o), 128'd0);

      // A request still high across reset release is taken as new
      br_data_i = mk_flit(2'd1, 8'h88, 16'h0000, 32'h88881111);
      br_req_i  = 1'b1;
      rst_ni    = 1'b0;
      tick();
      rst_ni = 1'b1;
      send_flit(mk_flit(2'd1, 8'h88, 16'h0000, 32'h88881111), 0);
      exp_q.push_back(mk_entry(8'h88, 16'h0000, 32'h88881111));
      chk("post_rst_count", 128'(count_o), 128'd1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/br_svc_rx.md
BR_SVC_RX -- requirements
Module: br_svc_rx

Interface
Parameters:
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of two, >= 2).
REQ-002 SHALL have parameter SEQ_ADDR, default 16'h0000, this PE's 16-bit sequential address used for target filtering.
Ports (name  direction  width  meaning):
REQ-003 SHALL have clk_i  in  1  clock, rising edge.
REQ-004 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have br_req_i  in  1  BrLite local-port request, level, held until acked.
REQ-006 SHALL have br_ack_o  out  1  one-cycle acknowledge to BrLite local port.
REQ-007 SHALL have br_data_i  in  106  incoming flit {service[105:104], ksvc[103:96], seq_source[95:80], seq_target[79:64], producer[63:48], payload[47:16]}; bits [15:0] unused.
REQ-008 SHALL have br_svc_rx_o  out  1  queue non-empty, to NI (IRQ source).
REQ-009 SHALL have br_svc_ack_i  in  1  NI pop pulse.
REQ-010 SHALL have br_svc_data_o  out  88  head entry {ksvc[87:80], seq_source[79:64], producer[63:48], payload[47:16], seq_target[15:0]}.
REQ-011 SHALL have count_o  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-012 Service codes SHALL be 2'd0 ALL, 2'd1 TARGET, 2'd2 MONITOR, 2'd3 CLEAR.
REQ-013 A flit is "storable" iff service==ALL, or service==TARGET and seq_target==SEQ_ADDR.
REQ-014 Non-storable flits (MONITOR, CLEAR, TARGET mismatch) SHALL be acked and discarded without touching the queue.
REQ-015 Receive FSM states: IDLE, ACK, WAIT.
REQ-016 IDLE: if br_req_i and (not storable, or count<DEPTH, or pop this cycle) -> capture/push if storable, go ACK; otherwise stay IDLE (backpressure, no ack).
REQ-017 ACK: br_ack_o=1 for exactly this cycle; go WAIT.
REQ-018 WAIT: br_ack_o=0; go IDLE when br_req_i==0; a flit is never accepted twice.
REQ-019 Push SHALL write the entry at the write pointer on the IDLE->ACK edge; count increments one cycle later, so the flit is visible on br_svc_rx_o in the ACK cycle.
REQ-020 br_svc_rx_o SHALL equal (count!=0); br_svc_data_o SHALL show the head entry combinationally from storage.
REQ-021 Pop: br_svc_ack_i==1 and count!=0 advances the read pointer and decrements count; pop when empty SHALL be ignored.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; with count==DEPTH a same-cycle pop permits the push.
REQ-023 Pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-024 Entry order SHALL be strict FIFO.

Reset
REQ-025 On rst_ni low, asynchronously: FSM=IDLE, br_ack_o=0, pointers=0, count_o=0, br_svc_rx_o=0; storage contents need not clear.
REQ-026 Reset mid-handshake SHALL abandon the flit; after release, a still-high br_req_i is treated as a new request.

Verification
REQ-027 ALL flit, ksvc=8'h12 payload=32'hCAFEBABE, empty queue -> br_ack_o pulse 1 cycle, br_svc_rx_o=1, head ksvc=8'h12 payload=32'hCAFEBABE, count_o=1.
REQ-028 TARGET flit seq_target=16'h0001 with SEQ_ADDR=0 -> acked, count_o stays 0; MONITOR and CLEAR flits same.
REQ-029 9 ALL flits with DEPTH=8, no pops -> first 8 acked, 9th held without ack; one br_svc_ack_i pulse -> 9th acked, count_o=8, order preserved payload 1..9.
REQ-030 br_req_i held high for 5 cycles after ack -> exactly one push, FSM in WAIT until req falls.
REQ-031 Push and pop same cycle at count_o=8 -> count_o remains 8, read/write pointers both wrap correctly over 20 iterations.
REQ-032 rst_ni asserted during ACK -> br_ack_o=0 immediately, count_o=0, br_svc_rx_o=0; pop pulse on empty queue -> no change.
